// File: rtl/avalon_block_reader_if.sv
// Bus bundle for avalon_block_reader: Avalon-MM read host signals plus the
// valid/ready output stream.
//   master : the block reader (drives avm_address/avm_read/avm_byteenable and the
//            stream; receives waitrequest/readdata/readdatavalid and st_ready)
//   slave  : the opposite side (memory agent plus stream consumer)
// Define BLOCK_READER_LAST_EN to add st_last (end-of-block marker) to the stream.
interface avalon_block_reader_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [31:0]       st_data;
  logic              st_valid;
  logic              st_ready;
`ifdef BLOCK_READER_LAST_EN
  logic              st_last;
`endif

  modport master (
    output avm_address, avm_read, avm_byteenable, st_data, st_valid,
`ifdef BLOCK_READER_LAST_EN
    output st_last,
`endif
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, st_ready
  );

  modport slave (
    input  avm_address, avm_read, avm_byteenable, st_data, st_valid,
`ifdef BLOCK_READER_LAST_EN
    input  st_last,
`endif
    output avm_waitrequest, avm_readdata, avm_readdatavalid, st_ready
  );
endinterface

// File: rtl/avalon_block_reader.sv
// Avalon-MM host that reads num_words consecutive 32-bit words starting at
// base_addr and delivers them in order on a valid/ready stream through a
// show-ahead FIFO. Reads are only issued while the FIFO has room for every
// word already in flight, so the FIFO can never overflow.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  command strobe, sampled only when idle
//   base_addr, num_words   block byte address (bits [1:0] ignored) and word count
//   busy, done             block in progress / 1-cycle completion pulse
//   bus (master modport)   Avalon read signals and output stream
// Optional feature macro: BLOCK_READER_LAST_EN adds st_last on the final word of a block.
module avalon_block_reader #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned LEN_W        = 12,
  parameter int unsigned FIFO_DEPTH_W = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    num_words,
  output logic                busy,
  output logic                done,
  avalon_block_reader_if.master bus
);
  localparam int unsigned Depth = 2 ** FIFO_DEPTH_W;
`ifdef BLOCK_READER_LAST_EN
  localparam int unsigned FifoW = 33;
`else
  localparam int unsigned FifoW = 32;
`endif
  localparam logic [FIFO_DEPTH_W+1:0] CreditMax = (FIFO_DEPTH_W + 2)'(Depth);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  logic [FIFO_DEPTH_W:0]   outstanding_q, outstanding_d;
  logic                    zero_done_q, zero_done_d;

  logic [FifoW-1:0]        fifo_mem [Depth];
  logic [FIFO_DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_W:0]   count_q;

  logic                    credit_ok, avm_read, accept, push, pop, fifo_valid;
  logic [FIFO_DEPTH_W+1:0] in_flight;
  logic [FifoW-1:0]        push_word, head;

  // Words requested but not yet consumed must all fit in the FIFO.
  assign in_flight  = {1'b0, outstanding_q} + {1'b0, count_q};
  assign credit_ok  = in_flight < CreditMax;
  // Credit cannot shrink without an accept, so a raised read stays raised while stalled.
  assign avm_read   = (state_q == StIssue) && credit_ok;
  assign accept     = avm_read && !bus.avm_waitrequest;
  // Returns with nothing outstanding are stale (e.g. from before a reset).
  assign push       = bus.avm_readdatavalid && (outstanding_q != '0);
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid && bus.st_ready;

`ifdef BLOCK_READER_LAST_EN
  logic last_word;
  // All reads issued and this is the only one left: it is the block's final word.
  assign last_word = (state_q == StDrain) && (outstanding_q == (FIFO_DEPTH_W + 1)'(1));
  assign push_word = {last_word, bus.avm_readdata};
  assign bus.st_last = fifo_valid && head[32];
`else
  assign push_word = bus.avm_readdata;
`endif

  assign head               = fifo_mem[rd_ptr_q];
  assign bus.st_valid       = fifo_valid;
  assign bus.st_data        = fifo_valid ? head[31:0] : 32'h0;
  assign bus.avm_read       = avm_read;
  assign bus.avm_address    = addr_q;
  assign bus.avm_byteenable = 4'hF;
  assign busy               = (state_q == StIssue) || (state_q == StDrain);
  assign done               = (state_q == StDone) || zero_done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    zero_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words != '0) begin
            addr_d      = base_addr & ~ADDR_W'(3);
            remaining_d = num_words;
            state_d     = StIssue;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (accept) begin
          addr_d      = addr_q + ADDR_W'(4);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (outstanding_q == '0 && count_q == '0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({accept, push})
      2'b10:   outstanding_d = outstanding_q + (FIFO_DEPTH_W + 1)'(1);
      2'b01:   outstanding_d = outstanding_q - (FIFO_DEPTH_W + 1)'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      zero_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      zero_done_q   <= zero_done_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (FIFO_DEPTH_W + 1)'(1);
        2'b01:   count_q <= count_q - (FIFO_DEPTH_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: st_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_word;
  end
endmodule

// File: tb/tb_avalon_block_reader.sv
`timescale 1ns/1ps
module tb_avalon_block_reader;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LEN_W  = 12;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_words;
  logic              busy, done;

  avalon_block_reader_if #(.ADDR_W(ADDR_W)) bus ();

  avalon_block_reader #(
    .ADDR_W      (ADDR_W),
    .LEN_W       (LEN_W),
    .FIFO_DEPTH_W(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .base_addr(base_addr),
    .num_words(num_words),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base;
    int          n;
    int          lat;
    int          wait_pct;
    int          ready_pct;
    logic [15:0] exp_last;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  int tests = 0, failed = 0;
  int cyc = 0;
  int acc_total = 0, ret_total = 0, xfer_total = 0, done_total = 0;
  int lat_k = 1, wait_pct = 0, ready_pct = 100;
  int inject_req = 0, inject_done = 0;
  logic [15:0] last_acc_addr = '0;
  logic [15:0] exp_addr[$];
  logic [31:0] exp_data[$];
  resp_t       ag_q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr = '0;

  // Memory contents seen by the agent: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  function automatic logic [15:0] last_addr(input logic [15:0] b, input int n);
    return (b & 16'hFFFC) + 16'(4 * (n - 1));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    tests++;
    failed++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference: a block is the word sequence at base, base+4, ... modulo 2**16.
  task automatic prep(input logic [15:0] b, input int n);
    logic [15:0] a;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      a = (b & 16'hFFFC) + 16'(4 * i);
      exp_addr.push_back(a);
      exp_data.push_back(mem_word(a));
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory agent, stream consumer and bus monitors; all act mid-cycle.
  always @(negedge clk) begin
    logic [15:0] ea;
    logic [31:0] ed;
    resp_t       r;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = 32'h0;
    if (ag_q.size() != 0 && ag_q[0].due <= cyc) begin
      r = ag_q.pop_front();
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = r.data;
      ret_total++;
    end else if (inject_req != inject_done) begin
      bus.avm_readdatavalid = 1'b1;
      bus.avm_readdata      = 32'hDEAD_BEEF;
      inject_done++;
    end
    bus.avm_waitrequest = ($urandom_range(99) < wait_pct);
    bus.st_ready        = ($urandom_range(99) < ready_pct);
    if (done === 1'b1) done_total++;
    if (reset_n === 1'b1) begin
      if (prev_stall) check("stall_hold", {bus.avm_read, bus.avm_address}, {1'b1, prev_addr});
      if (bus.avm_read && !bus.avm_waitrequest) begin
        acc_total++;
        last_acc_addr = bus.avm_address;
        if (exp_addr.size() == 0) fail_now("extra_read", "read accepted beyond block length");
        else begin
          ea = exp_addr.pop_front();
          check("rd_addr", {bus.avm_byteenable, bus.avm_address}, {4'hF, ea});
        end
        r.data = mem_word(bus.avm_address);
        r.due  = cyc + lat_k;
        ag_q.push_back(r);
      end
      prev_stall = bus.avm_read && bus.avm_waitrequest;
      prev_addr  = bus.avm_address;
      if (bus.st_valid && bus.st_ready) begin
        xfer_total++;
        if (exp_data.size() == 0) fail_now("extra_word", "stream word beyond block length");
        else begin
          ed = exp_data.pop_front();
          check("st_data", bus.st_data, ed);
`ifdef BLOCK_READER_LAST_EN
          check("st_last", bus.st_last, exp_data.size() == 0);
`endif
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_block(input vec_t v, input string tag, input bit mid_start);
    int acc0, xfer0, done0, first_v;
    bit seen_done;
    lat_k = v.lat; wait_pct = v.wait_pct; ready_pct = v.ready_pct;
    prep(v.base, v.n);
    acc0 = acc_total; xfer0 = xfer_total; done0 = done_total;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; num_words = LEN_W'(v.n);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1'b1);
    check({tag, "_read_first"}, bus.avm_read, 1'b1);
    first_v = -1; seen_done = 1'b0;
    for (int i = 2; i < 4000; i++) begin
      @(negedge clk);
      if (mid_start && i == 3) begin
        start = 1'b1; base_addr = 16'h4000; num_words = LEN_W'(3);
      end else start = 1'b0;
      if (first_v < 0 && bus.st_valid) first_v = i;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen_done) begin
      fail_now({tag, "_timeout"}, "done never pulsed");
      return;
    end
    check({tag, "_busy_at_done"}, busy, 1'b0);
    if (v.wait_pct == 0) check({tag, "_latency"}, first_v, 2 + v.lat);
    @(negedge clk);
    check({tag, "_done_clr"}, done, 1'b0);
    @(negedge clk);
    check({tag, "_idle"}, {busy, bus.avm_read}, 2'b00);
    check({tag, "_accepts"}, acc_total - acc0, v.n);
    check({tag, "_words"}, xfer_total - xfer0, v.n);
    check({tag, "_done_cnt"}, done_total - done0, 1);
    check({tag, "_last_addr"}, last_acc_addr, v.exp_last);
    check({tag, "_drained"}, exp_data.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    logic [31:0] rb;
    int acc0, xfer0, done0, rn;
    bit ok, saw;

    tbl[0] = '{16'h0010, 4, 1, 0, 100, 16'h001C};   // basic block
    tbl[1] = '{16'hFFF8, 4, 2, 0, 100, 16'h0004};   // address wrap
    tbl[2] = '{16'h0200, 12, 3, 50, 100, 16'h022C}; // random stalls
    tbl[3] = '{16'h1003, 6, 1, 50, 50, 16'h1014};   // unaligned base, back-pressure
    tbl[4] = '{16'h0040, 1, 1, 0, 100, 16'h0040};   // single word
    tbl[5] = '{16'h8000, 30, 4, 25, 70, 16'h8074};  // long block
    for (int k = 6; k < 8; k++) begin
      rb = $urandom;
      rn = $urandom_range(1, 40);
      tbl[k] = '{rb[15:0], rn, $urandom_range(1, 4), $urandom_range(0, 60),
                 $urandom_range(20, 100), last_addr(rb[15:0], rn)};
    end

    reset_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdata = '0;
    bus.avm_readdatavalid = 1'b0; bus.st_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_read", bus.avm_read, 1'b0);
    check("rst_addr", bus.avm_address, 16'h0);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_stream", {bus.st_valid, bus.st_data}, 33'h0);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 8; k++) run_block(tbl[k], $sformatf("vec%0d", k), 1'b0);

    // Back-pressure: credit limits reads to the FIFO depth.
    lat_k = 1; wait_pct = 0; ready_pct = 0;
    prep(16'h0100, 20);
    acc0 = acc_total; xfer0 = xfer_total;
    @(negedge clk); start = 1'b1; base_addr = 16'h0100; num_words = LEN_W'(20);
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    check("bp_accepts", acc_total - acc0, 8);
    check("bp_read_low", bus.avm_read, 1'b0);
    check("bp_head", {bus.st_valid, bus.st_data}, {1'b1, mem_word(16'h0100)});
    check("bp_no_xfer", xfer_total - xfer0, 0);
    ready_pct = 100;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("bp_timeout", "done never pulsed");
    @(negedge clk);
    check("bp_accepts_all", acc_total - acc0, 20);
    check("bp_words_all", xfer_total - xfer0, 20);
    check("bp_drained", exp_data.size(), 0);

    // Zero-length command.
    acc0 = acc_total; done0 = done_total;
    @(negedge clk); start = 1'b1; base_addr = 16'h0AA0; num_words = '0;
    @(negedge clk); start = 1'b0;
    check("zero_done", {done, busy, bus.avm_read}, 3'b100);
    @(negedge clk);
    check("zero_done_clr", {done, busy, bus.avm_read}, 3'b000);
    @(negedge clk);
    check("zero_no_read", acc_total - acc0, 0);
    check("zero_done_cnt", done_total - done0, 1);

    // Start while busy must be ignored.
    v = '{16'h2000, 6, 2, 0, 100, 16'h2014};
    run_block(v, "busy_start", 1'b1);

    // Reset in the middle of a block with reads outstanding.
    lat_k = 5; wait_pct = 0; ready_pct = 100;
    prep(16'h0300, 10);
    @(negedge clk); start = 1'b1; base_addr = 16'h0300; num_words = LEN_W'(10);
    @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (acc_total - ret_total >= 3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_now("mid_rst_setup", "never reached 3 outstanding reads");
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_avm", {bus.avm_read, bus.avm_address}, 17'h0);
    check("mid_rst_ctrl", {busy, done}, 2'b00);
    check("mid_rst_stream", {bus.st_valid, bus.st_data}, 33'h0);
`ifdef BLOCK_READER_LAST_EN
    check("mid_rst_last", bus.st_last, 1'b0);
`endif
    exp_addr.delete();
    exp_data.delete();
    @(negedge clk);
    #1 reset_n = 1'b1;
    inject_req++;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.st_valid || busy) saw = 1'b1;
      if (i > 5 && ag_q.size() == 0 && inject_done == inject_req) break;
    end
    check("stale_dropped", saw, 1'b0);
    v = '{16'h0500, 5, 1, 0, 100, 16'h0510};
    run_block(v, "post_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
